// File: rtl/col_sweep_engine.sv
// rtl/col_sweep_engine.sv - drum mesh column controller: LUT init, bottom-to-top sweep, tapped output.
// Optional PEAK_TRACK_EN adds peak_clr / peak_abs magnitude tracking of tapped values.
module col_sweep_engine #(
    parameter int DATA_W   = 18,
    parameter int ADDR_W   = 19,
    parameter int ROWS     = 30,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shoot,
    input  logic              reinit,
    input  logic [ADDR_W-1:0] tap_row,
    output logic [ADDR_W-1:0] lut_addr,
    input  logic [DATA_W-1:0] lut_data,
    input  logic [DATA_W-1:0] left_column,
    input  logic [DATA_W-1:0] right_column,
    input  logic [DATA_W-1:0] M10k_out,
    input  logic [DATA_W-1:0] M10k_out_1,
    output logic [ADDR_W-1:0] read_address,
    output logic [ADDR_W-1:0] read_address_1,
    output logic [ADDR_W-1:0] write_address,
    output logic [ADDR_W-1:0] write_address_1,
    output logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] write_data_1,
    output logic              write_enable,
    output logic              write_enable_1,
    output logic [DATA_W-1:0] solver_uij_left,
    output logic [DATA_W-1:0] solver_uij_right,
    output logic [DATA_W-1:0] solver_uij_up,
    output logic [DATA_W-1:0] solver_uij_down,
    output logic [DATA_W-1:0] solver_uij_in,
    output logic [DATA_W-1:0] solver_uij_prev_in,
    input  logic [DATA_W-1:0] solver_uij_next,
    output logic [DATA_W-1:0] me,
    output logic [DATA_W-1:0] output_node,
    output logic              busy,
    output logic              ready,
    output logic              done
`ifdef PEAK_TRACK_EN
    ,
    input  logic              peak_clr,
    output logic [DATA_W-1:0] peak_abs
`endif
);

    typedef enum logic [2:0] {
        S_INIT, S_READY, S_PRIME, S_RD, S_WAIT, S_COMP, S_TAP
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] NUM_ROWS = ADDR_W'(ROWS);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [1:0]        LAT      = 2'(READ_LAT);
    localparam logic [1:0]        LAT_M1   = 2'(READ_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] uij_q, uij_d;
    logic [DATA_W-1:0] down_q, down_d;
    logic [ADDR_W-1:0] tap_q, tap_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic              done_q, done_d;

    logic              last_row;
    logic [ADDR_W-1:0] next_row;
    logic [ADDR_W-1:0] tap_clamped;

    assign last_row    = (row_q == LAST_ROW);
    assign next_row    = last_row ? '0 : row_q + ONE;
    assign tap_clamped = (tap_row >= NUM_ROWS) ? LAST_ROW : tap_row;

    assign solver_uij_left  = left_column;
    assign solver_uij_right = right_column;
    assign me               = uij_q;
    assign output_node      = out_q;
    assign done             = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            row_q   <= '0;
            cnt_q   <= '0;
            uij_q   <= '0;
            down_q  <= '0;
            tap_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            uij_q   <= uij_d;
            down_q  <= down_d;
            tap_q   <= tap_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        row_d              = row_q;
        cnt_d              = cnt_q;
        uij_d              = uij_q;
        down_d             = down_q;
        tap_d              = tap_q;
        out_d              = out_q;
        done_d             = 1'b0;
        lut_addr           = '0;
        read_address       = '0;
        read_address_1     = '0;
        write_address      = '0;
        write_address_1    = '0;
        write_data         = '0;
        write_data_1       = '0;
        write_enable       = 1'b0;
        write_enable_1     = 1'b0;
        solver_uij_up      = '0;
        solver_uij_down    = '0;
        solver_uij_in      = '0;
        solver_uij_prev_in = '0;
        busy               = 1'b1;
        ready              = 1'b0;

        case (state_q)
            S_INIT: begin
                // Strobes are masked while reset is held so no write escapes during reset.
                lut_addr        = row_q;
                write_address   = row_q;
                write_address_1 = row_q;
                write_data      = lut_data;
                write_data_1    = lut_data;
                write_enable    = rst_n;
                write_enable_1  = rst_n;
                if (last_row) begin
                    row_d   = '0;
                    state_d = S_READY;
                end else begin
                    row_d = row_q + ONE;
                end
            end
            S_READY: begin
                busy  = 1'b0;
                ready = 1'b1;
                if (reinit) begin
                    row_d   = '0;
                    state_d = S_INIT;
                end else if (shoot) begin
                    cnt_d   = '0;
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                if (cnt_q == LAT) begin
                    uij_d   = M10k_out;
                    down_d  = '0;
                    row_d   = '0;
                    cnt_d   = '0;
                    state_d = S_RD;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_RD: begin
                read_address   = next_row;
                read_address_1 = row_q;
                cnt_d          = '0;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                read_address   = next_row;
                read_address_1 = row_q;
                if (cnt_q == LAT_M1) begin
                    cnt_d   = '0;
                    state_d = S_COMP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_COMP: begin
                // down_q/uij_q still hold u^n, so neighbours are never this sweep's results.
                read_address       = next_row;
                read_address_1     = row_q;
                solver_uij_up      = last_row ? '0 : M10k_out;
                solver_uij_down    = (row_q == '0) ? '0 : down_q;
                solver_uij_in      = uij_q;
                solver_uij_prev_in = M10k_out_1;
                write_address      = row_q;
                write_address_1    = row_q;
                write_data         = solver_uij_next;
                write_data_1       = uij_q;
                write_enable       = 1'b1;
                write_enable_1     = 1'b1;
                down_d             = uij_q;
                uij_d              = M10k_out;
                cnt_d              = '0;
                if (last_row) begin
                    tap_d   = tap_clamped;
                    state_d = S_TAP;
                end else begin
                    row_d   = row_q + ONE;
                    state_d = S_RD;
                end
            end
            S_TAP: begin
                read_address = tap_q;
                if (cnt_q == LAT) begin
                    out_d   = M10k_out;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

`ifdef PEAK_TRACK_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] peak_q, peak_d;
    logic [DATA_W-1:0] tap_abs;

    always_comb begin
        tap_abs = M10k_out;
        if (M10k_out == MOST_NEG) begin
            tap_abs = MAX_POS;
        end else if (M10k_out[DATA_W-1]) begin
            tap_abs = ~M10k_out + DATA_W'(1);
        end
        peak_d = peak_q;
        if (peak_clr || (state_q == S_READY && reinit)) begin
            peak_d = '0;
        end else if (done_d && (tap_abs > peak_q)) begin
            peak_d = tap_abs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_col_sweep_engine.sv
// tb/tb_col_sweep_engine.sv - self-checking bench for col_sweep_engine with a column-level reference model.
module tb_col_sweep_engine;

    localparam int DATA_W   = 18;
    localparam int ADDR_W   = 19;
    localparam int ROWS     = 4;
    localparam int READ_LAT = 1;
    localparam int SWEEP_LAT = (1 + READ_LAT) + ROWS * (2 + READ_LAT) + (1 + READ_LAT);

    logic              clk;
    logic              rst_n;
    logic              shoot;
    logic              reinit;
    logic [ADDR_W-1:0] tap_row;
    logic [ADDR_W-1:0] lut_addr;
    logic [DATA_W-1:0] lut_data;
    logic [DATA_W-1:0] left_column;
    logic [DATA_W-1:0] right_column;
    logic [DATA_W-1:0] M10k_out;
    logic [DATA_W-1:0] M10k_out_1;
    logic [ADDR_W-1:0] read_address;
    logic [ADDR_W-1:0] read_address_1;
    logic [ADDR_W-1:0] write_address;
    logic [ADDR_W-1:0] write_address_1;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] write_data_1;
    logic              write_enable;
    logic              write_enable_1;
    logic [DATA_W-1:0] solver_uij_left;
    logic [DATA_W-1:0] solver_uij_right;
    logic [DATA_W-1:0] solver_uij_up;
    logic [DATA_W-1:0] solver_uij_down;
    logic [DATA_W-1:0] solver_uij_in;
    logic [DATA_W-1:0] solver_uij_prev_in;
    logic [DATA_W-1:0] solver_uij_next;
    logic [DATA_W-1:0] me;
    logic [DATA_W-1:0] output_node;
    logic              busy;
    logic              ready;
    logic              done;
`ifdef PEAK_TRACK_EN
    logic              peak_clr;
    logic [DATA_W-1:0] peak_abs;
    int                m_peak;
`endif

    logic [DATA_W-1:0] lut      [8];
    logic [DATA_W-1:0] mem_cur  [8];
    logic [DATA_W-1:0] mem_prev [8];
    logic [DATA_W-1:0] m_cur    [ROWS];
    logic [DATA_W-1:0] m_prev   [ROWS];

    int errors = 0;
    int checks = 0;

    col_sweep_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ROWS(ROWS), .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .shoot(shoot), .reinit(reinit), .tap_row(tap_row),
        .lut_addr(lut_addr), .lut_data(lut_data),
        .left_column(left_column), .right_column(right_column),
        .M10k_out(M10k_out), .M10k_out_1(M10k_out_1),
        .read_address(read_address), .read_address_1(read_address_1),
        .write_address(write_address), .write_address_1(write_address_1),
        .write_data(write_data), .write_data_1(write_data_1),
        .write_enable(write_enable), .write_enable_1(write_enable_1),
        .solver_uij_left(solver_uij_left), .solver_uij_right(solver_uij_right),
        .solver_uij_up(solver_uij_up), .solver_uij_down(solver_uij_down),
        .solver_uij_in(solver_uij_in), .solver_uij_prev_in(solver_uij_prev_in),
        .solver_uij_next(solver_uij_next), .me(me), .output_node(output_node),
        .busy(busy), .ready(ready), .done(done)
`ifdef PEAK_TRACK_EN
        , .peak_clr(peak_clr), .peak_abs(peak_abs)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment: init LUT, two single-port-read M10K banks with one-cycle registered read, solver next = up + down.
    assign lut_data        = lut[lut_addr[2:0]];
    assign solver_uij_next = solver_uij_up + solver_uij_down;

    always @(posedge clk) begin
        if (write_enable)   mem_cur[write_address[2:0]]    <= write_data;
        if (write_enable_1) mem_prev[write_address_1[2:0]] <= write_data_1;
        M10k_out   <= mem_cur[read_address[2:0]];
        M10k_out_1 <= mem_prev[read_address_1[2:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_banks(input string tag);
        for (int i = 0; i < ROWS; i++) begin
            check($sformatf("%s_cur[%0d]", tag, i), mem_cur[i], m_cur[i]);
            check($sformatf("%s_prev[%0d]", tag, i), mem_prev[i], m_prev[i]);
        end
    endtask

    function automatic int mag(input logic [DATA_W-1:0] v);
        int sv;
        sv = $signed(v);
        if (sv == -(1 << (DATA_W - 1))) return (1 << (DATA_W - 1)) - 1;
        return (sv < 0) ? -sv : sv;
    endfunction

    // Wave-equation column step seen as whole arrays: new[i] = old[i+1] + old[i-1], edges padded with 0.
    task automatic model_sweep(input logic [ADDR_W-1:0] tap, output logic [DATA_W-1:0] exp_out);
        logic [DATA_W-1:0] nxt [ROWS];
        int t;
        for (int i = 0; i < ROWS; i++) begin
            nxt[i] = ((i < ROWS - 1) ? m_cur[i+1] : '0) + ((i > 0) ? m_cur[i-1] : '0);
        end
        for (int i = 0; i < ROWS; i++) begin
            m_prev[i] = m_cur[i];
            m_cur[i]  = nxt[i];
        end
        t = (tap >= ADDR_W'(ROWS)) ? ROWS - 1 : int'(tap);
        exp_out = m_cur[t];
    endtask

    task automatic model_load();
        for (int i = 0; i < ROWS; i++) begin
            m_cur[i]  = lut[i];
            m_prev[i] = lut[i];
        end
    endtask

    task automatic do_sweep(input logic [ADDR_W-1:0] tap, input int extra_at, input bit clr_at_done);
        logic [DATA_W-1:0] exp_out;
        int n;
        int stray;
        bit got;
        model_sweep(tap, exp_out);
        tap_row = tap;
        shoot   = 1'b1;
        step();
        shoot = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 4 * SWEEP_LAT && !got) begin
            step();
            n++;
            if (extra_at != 0 && n == extra_at) shoot = 1'b1;
            if (extra_at != 0 && n == extra_at + 1) shoot = 1'b0;
            if (n == SWEEP_LAT - 2) tap_row = ADDR_W'($urandom);
`ifdef PEAK_TRACK_EN
            if (clr_at_done && n == SWEEP_LAT - 1) peak_clr = 1'b1;
`endif
            if (done) got = 1'b1;
        end
`ifdef PEAK_TRACK_EN
        peak_clr = 1'b0;
        if (clr_at_done) m_peak = 0;
        else if (mag(exp_out) > m_peak) m_peak = mag(exp_out);
        check("peak_abs", peak_abs, m_peak);
`else
        if (clr_at_done) n = n + 0;
`endif
        check("done_seen", got, 1);
        check("done_latency", n, SWEEP_LAT);
        check("output_node", output_node, exp_out);
        check("ready_after_done", ready, 1);
        check("busy_after_done", busy, 0);
        step();
        check("done_width", done, 0);
        if (extra_at != 0) begin
            stray = 0;
            repeat (20) begin
                step();
                if (done || busy) stray++;
            end
            check("ignored_shoot_stray", stray, 0);
        end
        check_banks("sweep");
    endtask

    task automatic do_reinit(input bit with_shoot);
        int dones;
        reinit = 1'b1;
        shoot  = with_shoot;
        step();
        reinit = 1'b0;
        shoot  = 1'b0;
        check("reinit_busy", busy, 1);
        check("reinit_ready", ready, 0);
        dones = 0;
        repeat (ROWS) begin
            step();
            if (done) dones++;
        end
        check("reinit_no_done", dones, 0);
        check("reinit_ready_end", ready, 1);
        model_load();
`ifdef PEAK_TRACK_EN
        m_peak = 0;
        check("reinit_peak", peak_abs, 0);
`endif
        check_banks("reinit");
    endtask

    initial begin
        rst_n        = 1'b0;
        shoot        = 1'b0;
        reinit       = 1'b0;
        tap_row      = '0;
        left_column  = '0;
        right_column = '0;
`ifdef PEAK_TRACK_EN
        peak_clr = 1'b0;
        m_peak   = 0;
`endif
        for (int i = 0; i < 8; i++) begin
            lut[i]      = (i < ROWS) ? DATA_W'(10 * (i + 1)) : '0;
            mem_cur[i]  = '0;
            mem_prev[i] = '0;
        end

        step();
        step();
        check("rst_busy", busy, 1);
        check("rst_ready", ready, 0);
        check("rst_done", done, 0);
        check("rst_output_node", output_node, 0);
        check("rst_we", write_enable, 0);
        check("rst_we1", write_enable_1, 0);

        rst_n = 1'b1;
        #1;
        check("init_lut_addr0", lut_addr, 0);
        repeat (ROWS - 1) step();
        check("init_busy_mid", busy, 1);
        step();
        check("init_ready", ready, 1);
        check("init_busy", busy, 0);
        check("init_output_node", output_node, 0);
        model_load();
        check_banks("init");

        left_column  = DATA_W'($urandom);
        right_column = DATA_W'($urandom);
        #1;
        check("pass_left", solver_uij_left, left_column);
        check("pass_right", solver_uij_right, right_column);
        check("idle_solver_in", solver_uij_in, 0);
        check("idle_solver_up", solver_uij_up, 0);

        do_sweep(ADDR_W'(2), 0, 1'b0);
        check("plan_sweep1_out", output_node, 60);
        check("plan_sweep1_cur2", mem_cur[2], 60);
        do_sweep(ADDR_W'(9), 0, 1'b0);
        check("plan_sweep2_out", output_node, 60);
        check("plan_sweep2_cur1", mem_cur[1], 80);

        do_reinit(1'b1);
        check("plan_reinit_cur3", mem_cur[3], 40);

        do_sweep(ADDR_W'(1), 5, 1'b0);

        tap_row = ADDR_W'(1);
        shoot   = 1'b1;
        step();
        shoot = 1'b0;
        repeat (2 + 2 * (2 + READ_LAT)) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 1);
        check("midrst_ready", ready, 0);
        check("midrst_done", done, 0);
        check("midrst_we", write_enable, 0);
        step();
        rst_n = 1'b1;
        #1;
        check("midrst_lut_addr", lut_addr, 0);
        check("midrst_wr_addr", write_address, 0);
        repeat (ROWS) step();
        check("midrst_ready_end", ready, 1);
        model_load();
`ifdef PEAK_TRACK_EN
        m_peak = 0;
`endif
        check_banks("midrst");

        for (int r = 0; r < 6; r++) begin
            if (r % 2 == 0) begin
                for (int i = 0; i < ROWS; i++) lut[i] = DATA_W'($urandom);
                do_reinit(1'b0);
            end
            do_sweep(ADDR_W'($urandom_range(0, 9)), 0, 1'b0);
            do_sweep(ADDR_W'($urandom_range(0, 9)), 0, 1'b0);
        end
        do_sweep(ADDR_W'($urandom_range(0, 3)), 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/col_sweep_engine.md
Name: col_sweep_engine

Overview:
- Parametrised next-generation column controller for the FPGA drum mesh solver.
- Owns one mesh column held in two M10K banks: current timestep u^n and previous timestep u^(n-1).
- Initialises both banks from an external init LUT, then on each shoot pulse sweeps the column bottom-to-top. Each sweep feeds the combinational node solver and writes u^(n+1) and u^n back.
- Generalises the fixed 30-row, 1-cycle-latency, fixed-center-tap column FSM with: configurable row count and M10K read latency, run-time tap row selection, re-initialisation without reset, and a busy/ready/done handshake.

Parameters:
- DATA_W, 18, node value width (signed fixed point)
- ADDR_W, 19, M10K address width
- ROWS, 30, rows in the column (2..512)
- READ_LAT, 1, M10K read latency in cycles (1..3)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- shoot  in  1  start one sweep; honoured only in S_READY
- reinit  in  1  reload column from LUT; honoured only in S_READY, and wins over a simultaneous shoot
- tap_row  in  ADDR_W  row sampled to output_node at the end of each sweep; values >= ROWS clamp to ROWS-1
- lut_addr  out  ADDR_W  init LUT row address
- lut_data  in  DATA_W  init LUT value, combinational from lut_addr
- left_column, right_column  in  DATA_W  neighbour column values, passed straight through
- M10k_out, M10k_out_1  in  DATA_W  read data from the current and previous banks
- read_address, read_address_1, write_address, write_address_1  out  ADDR_W  bank addresses
- write_data, write_data_1  out  DATA_W  bank write data
- write_enable, write_enable_1  out  1  bank write strobes
- solver_uij_left, solver_uij_right, solver_uij_up, solver_uij_down, solver_uij_in, solver_uij_prev_in  out  DATA_W  solver operands
- solver_uij_next  in  DATA_W  solver result, combinational
- me  out  DATA_W  u^n of the row currently being computed
- output_node  out  DATA_W  tapped node value
- busy  out  1  init or sweep in progress
- ready  out  1  idle in S_READY
- done  out  1  one-cycle pulse when output_node updates

Behaviour:
- Reset (async, rst_n low):
  - state = S_INIT; all counters and registers cleared.
  - Outputs: output_node = 0, done = 0, all write enables 0, busy = 1, ready = 0.
- S_INIT: for k = 0..ROWS-1, one row per cycle:
  - lut_addr = k.
  - Both banks write address k with lut_data.
  - After row ROWS-1, go to S_READY.
- S_READY: busy = 0, ready = 1, no writes.
  - reinit: reset k to 0 and go to S_INIT.
  - else shoot: go to S_PRIME.
  - shoot and reinit are ignored in every other state.
- S_PRIME:
  - read_address = 0.
  - After READ_LAT cycles, latch M10k_out into uij_reg; down_reg = 0; i = 0.
  - Go to S_RD.
- Row loop, row i:
  - S_RD: read_address = i+1 (0 when i = ROWS-1); read_address_1 = i.
  - S_WAIT: held READ_LAT cycles, same addresses.
  - S_COMP, single cycle, solver operands:
    - up = M10k_out (0 when i = ROWS-1)
    - down = down_reg (0 when i = 0)
    - in = uij_reg
    - prev_in = M10k_out_1
  - S_COMP writes:
    - current bank: address i, data solver_uij_next, write_enable = 1
    - previous bank: address i, data uij_reg, write_enable_1 = 1
  - S_COMP register updates: down_reg <= uij_reg; uij_reg <= M10k_out.
  - Transition: if i == ROWS-1 go to S_TAP, else i+1 and back to S_RD.
- Row timing: 2+READ_LAT cycles per row.
- S_TAP:
  - read_address = clamped tap_row, sampled on entry.
  - After READ_LAT cycles, output_node <= M10k_out, done = 1 for that cycle.
  - Go to S_READY.
- Sweep latency: shoot accepted to done pulse = (1+READ_LAT) + ROWS*(2+READ_LAT) + (1+READ_LAT) cycles.
- Down and in operands are always u^n values: a row never sees a neighbour already updated in the same sweep.
- solver_uij_left/right = left_column/right_column in every state.
- me = uij_reg.
- Solver operands are 0 outside S_COMP.
- Asserting rst_n low mid-sweep aborts immediately; bank contents are undefined until S_INIT completes.

Optional Feature:
- PEAK_TRACK_EN defined:
  - Adds output peak_abs (DATA_W, unsigned magnitude) and input peak_clr.
  - On every done, peak_abs <= max(peak_abs, |output_node new|); the most-negative value saturates to the max positive.
  - peak_clr or entering S_INIT zeroes it; peak_clr has priority over a same-cycle done.
- PEAK_TRACK_EN undefined: ports absent, no extra logic.

Test Plan:
- Bench setup for all scenarios: ROWS=4, READ_LAT=1, LUT = 10,20,30,40, solver model next = up+down.
- Reset then init: after 4 cycles both banks = [10,20,30,40], ready=1, busy=0, output_node=0.
- Sweep with tap_row=2, shoot pulse:
  - current bank = [20,40,60,30], previous bank = [10,20,30,40].
  - output_node = 60.
  - done high 1 cycle, exactly 16 cycles after shoot accepted.
- Second shoot with tap_row=9 (clamps to 3): current = [40,80,70,60], previous = [20,40,60,30], output_node = 60.
- shoot and reinit asserted together in S_READY: re-init runs, banks return to [10,20,30,40], no sweep, no done.
- Shoot during a sweep is ignored; rst_n low at row 2 gives immediate busy=1, ready=0, done=0 and re-init from row 0.
- PEAK_TRACK_EN: taps of 60 then -75 give peak_abs = 75; peak_clr in the same cycle as done gives peak_abs = 0.
